// File: rtl/channel_seq_pkg.sv
// Shared types, channel codes and step-order helper for the channel sequencer.
package channel_seq_pkg;

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'b00,
      MODE_BUTTON = 2'b01,
      MODE_AUTO   = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_t;

   localparam logic [2:0] CH_G  = 3'd0;
   localparam logic [2:0] CH_R  = 3'd1;
   localparam logic [2:0] CH_B  = 3'd2;
   localparam logic [2:0] CH_Y  = 3'd4;
   localparam logic [2:0] CH_CR = 3'd5;
   localparam logic [2:0] CH_CB = 3'd6;

   // Black codes 3 and 7 rejoin the cycle at the next real channel.
   function automatic logic [2:0] next_channel(input logic [2:0] c);
      logic [2:0] n;
      case (c)
         CH_G:    n = CH_R;
         CH_R:    n = CH_B;
         CH_B:    n = CH_Y;
         3'd3:    n = CH_Y;
         CH_Y:    n = CH_CR;
         CH_CR:   n = CH_CB;
         default: n = CH_G;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/channel_sequencer_debouncer.sv
// Button conditioning: 2-flop synchronizer followed by a stability counter.
// Used by channel_sequencer only when CHANNEL_SEQ_DEBOUNCE_EN is defined.
module button_debouncer
   import channel_seq_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic btn_in,
   output logic level_out
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q;

   // Counter runs only while the synchronized input disagrees with the accepted level.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync_q    <= 2'b00;
         cnt_q     <= '0;
         level_out <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_in};
         if (sync_q[1] == level_out) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            level_out <= sync_q[1];
            cnt_q     <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/channel_sequencer.sv
// Frame-aligned channel select controller (manual / button-step / auto-cycle / hold).
// Define CHANNEL_SEQ_DEBOUNCE_EN to synchronize and debounce btn_in.
module channel_sequencer
   import channel_seq_pkg::*;
#(
   parameter int unsigned FRAMES_PER_STEP = 60,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [1:0] mode_in,
   input  logic [2:0] sw_in,
   input  logic       btn_in,
   input  logic       new_frame_in,
   output logic [2:0] select_out,
   output logic       select_changed_out,
   output logic       pending_out
);

   localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

   logic [2:0]       target_q;
   logic [CNT_W-1:0] cnt_q;
   logic             btn_q;
   mode_t            mode_q;
   mode_t            mode_cur;
   logic             btn_lvl;

   assign mode_cur = mode_t'(mode_in);

`ifdef CHANNEL_SEQ_DEBOUNCE_EN
   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .btn_in   (btn_in),
      .level_out(btn_lvl)
   );
`else
   logic unused_debounce_cycles;
   assign unused_debounce_cycles = (DEBOUNCE_CYCLES == 0);
   assign btn_lvl = btn_in;
`endif

   assign pending_out = (target_q != select_out);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         select_out         <= CH_G;
         select_changed_out <= 1'b0;
         target_q           <= CH_G;
         cnt_q              <= '0;
         btn_q              <= 1'b0;
         mode_q             <= MODE_MANUAL;
      end else begin
         btn_q  <= btn_lvl;
         mode_q <= mode_cur;

         // Commit uses the target held at the start of the cycle.
         if (new_frame_in) begin
            select_out         <= target_q;
            select_changed_out <= (target_q != select_out);
         end else begin
            select_changed_out <= 1'b0;
         end

         if (mode_cur != mode_q) begin
            cnt_q <= '0;
            if (mode_cur == MODE_MANUAL) target_q <= sw_in;
         end else begin
            unique case (mode_cur)
               MODE_MANUAL: target_q <= sw_in;
               MODE_BUTTON: begin
                  if (btn_lvl && !btn_q) target_q <= next_channel(target_q);
               end
               MODE_AUTO: begin
                  if (new_frame_in) begin
                     if (cnt_q == CNT_LAST) begin
                        cnt_q    <= '0;
                        target_q <= next_channel(target_q);
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
               end
               MODE_HOLD: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_channel_sequencer.sv
// Directed self-checking bench for channel_sequencer (FRAMES_PER_STEP=3 and =1 instances).
module tb_channel_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic [2:0] sw;
   logic       btn;
   logic       nf;
   logic [2:0] sel;
   logic       chg;
   logic       pend;
   logic [2:0] sel1;
   logic       chg1;
   logic       pend1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   channel_sequencer #(
      .FRAMES_PER_STEP(3),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .mode_in           (mode),
      .sw_in             (sw),
      .btn_in            (btn),
      .new_frame_in      (nf),
      .select_out        (sel),
      .select_changed_out(chg),
      .pending_out       (pend)
   );

   channel_sequencer #(
      .FRAMES_PER_STEP(1),
      .DEBOUNCE_CYCLES(4)
   ) dut1 (
      .clk_in            (clk),
      .rst_in            (rst),
      .mode_in           (mode),
      .sw_in             (sw),
      .btn_in            (btn),
      .new_frame_in      (nf),
      .select_out        (sel1),
      .select_changed_out(chg1),
      .pending_out       (pend1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      nf = 1'b1;
      tick();
      nf = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 2'b00; sw = 3'd5; btn = 1'b0; nf = 1'b0;
      tick(); tick();
      total++; if (sel !== 3'd0) begin bad++; $display("FAIL reset_select got=%0d exp=0", sel); end
      total++; if (chg !== 1'b0) begin bad++; $display("FAIL reset_changed got=%0b exp=0", chg); end
      total++; if (pend !== 1'b0) begin bad++; $display("FAIL reset_pending got=%0b exp=0", pend); end
      rst = 1'b0;
      tick();
      total++; if (pend !== 1'b1) begin bad++; $display("FAIL reset_release_pending got=%0b exp=1", pend); end
      total++; if (sel !== 3'd0) begin bad++; $display("FAIL reset_release_select got=%0d exp=0", sel); end
   endtask

   task automatic test_button();
      logic [2:0] exp_seq [7] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
      sw = 3'd0;
      tick();
      frame();
      mode = 2'b01;
      tick();
      for (int i = 0; i < 7; i++) begin
         btn = 1'b1; tick();
         btn = 1'b0; tick();
         frame();
         total++; if (sel !== exp_seq[i]) begin bad++; $display("FAIL button_step%0d select got=%0d exp=%0d", i, sel, exp_seq[i]); end
         total++; if (chg !== 1'b1) begin bad++; $display("FAIL button_step%0d changed got=%0b exp=1", i, chg); end
         tick();
         total++; if (chg !== 1'b0) begin bad++; $display("FAIL button_step%0d changed_drop got=%0b exp=0", i, chg); end
      end
      btn = 1'b1;
      for (int i = 0; i < 100; i++) tick();
      btn = 1'b0;
      tick();
      frame();
      total++; if (sel !== 3'd2) begin bad++; $display("FAIL button_held select got=%0d exp=2", sel); end
      frame();
      total++; if (sel !== 3'd2) begin bad++; $display("FAIL button_held_single select got=%0d exp=2", sel); end
      total++; if (chg !== 1'b0) begin bad++; $display("FAIL button_held_single changed got=%0b exp=0", chg); end
   endtask

   task automatic test_back_to_back();
      btn = 1'b1; nf = 1'b1;
      tick();
      btn = 1'b0; nf = 1'b0;
      total++; if (sel !== 3'd2) begin bad++; $display("FAIL b2b_select got=%0d exp=2", sel); end
      total++; if (chg !== 1'b0) begin bad++; $display("FAIL b2b_changed got=%0b exp=0", chg); end
      total++; if (pend !== 1'b1) begin bad++; $display("FAIL b2b_pending got=%0b exp=1", pend); end
      tick();
      frame();
      total++; if (sel !== 3'd4) begin bad++; $display("FAIL b2b_next select got=%0d exp=4", sel); end
      total++; if (chg !== 1'b1) begin bad++; $display("FAIL b2b_next changed got=%0b exp=1", chg); end
   endtask

   task automatic test_manual();
      mode = 2'b00; sw = 3'b101;
      tick(); tick(); tick();
      total++; if (pend !== 1'b1) begin bad++; $display("FAIL manual_pending got=%0b exp=1", pend); end
      total++; if (sel !== 3'd4) begin bad++; $display("FAIL manual_hold_select got=%0d exp=4", sel); end
      frame();
      total++; if (sel !== 3'd5) begin bad++; $display("FAIL manual_commit select got=%0d exp=5", sel); end
      total++; if (chg !== 1'b1) begin bad++; $display("FAIL manual_commit changed got=%0b exp=1", chg); end
      total++; if (pend !== 1'b0) begin bad++; $display("FAIL manual_commit pending got=%0b exp=0", pend); end
      sw = 3'd3;
      tick();
      total++; if (pend !== 1'b1) begin bad++; $display("FAIL manual_black_pending got=%0b exp=1", pend); end
      frame();
      total++; if (sel !== 3'd3) begin bad++; $display("FAIL manual_black select got=%0d exp=3", sel); end
      total++; if (chg !== 1'b1) begin bad++; $display("FAIL manual_black changed got=%0b exp=1", chg); end
   endtask

   task automatic test_auto();
      logic [2:0] exp_sel [9] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2};
      logic [2:0] exp_tgt [9] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4};
      logic       exp_chg [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      sw = 3'd0;
      tick();
      frame();
      mode = 2'b10;
      tick();
      for (int p = 0; p < 9; p++) begin
         frame();
         total++; if (sel !== exp_sel[p]) begin bad++; $display("FAIL auto_pulse%0d select got=%0d exp=%0d", p + 1, sel, exp_sel[p]); end
         total++; if (chg !== exp_chg[p]) begin bad++; $display("FAIL auto_pulse%0d changed got=%0b exp=%0b", p + 1, chg, exp_chg[p]); end
         total++; if (dut.target_q !== exp_tgt[p]) begin bad++; $display("FAIL auto_pulse%0d target got=%0d exp=%0d", p + 1, dut.target_q, exp_tgt[p]); end
         tick();
      end
   endtask

   task automatic test_reset_pending();
      // Pulses 10..15 move target to 6 with 5 committed; pulses 10..11 leave cnt at 2.
      for (int p = 0; p < 2; p++) begin frame(); tick(); end
      total++; if (dut.cnt_q !== 2'd2) begin bad++; $display("FAIL midrun_cnt got=%0d exp=2", dut.cnt_q); end
      for (int p = 0; p < 4; p++) begin frame(); tick(); end
      total++; if (pend !== 1'b1 || dut.target_q !== 3'd6 || sel !== 3'd5) begin
         bad++; $display("FAIL prereset_state pend=%0b target=%0d select=%0d exp 1/6/5", pend, dut.target_q, sel);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (sel !== 3'd0) begin bad++; $display("FAIL midreset_select got=%0d exp=0", sel); end
      total++; if (dut.target_q !== 3'd0) begin bad++; $display("FAIL midreset_target got=%0d exp=0", dut.target_q); end
      total++; if (dut.cnt_q !== 2'd0) begin bad++; $display("FAIL midreset_cnt got=%0d exp=0", dut.cnt_q); end
      total++; if (pend !== 1'b0) begin bad++; $display("FAIL midreset_pending got=%0b exp=0", pend); end
      total++; if (chg !== 1'b0) begin bad++; $display("FAIL midreset_changed got=%0b exp=0", chg); end
   endtask

   task automatic test_fps_one();
      tick();
      frame();
      total++; if (sel1 !== 3'd0) begin bad++; $display("FAIL fps1_f1 select got=%0d exp=0", sel1); end
      total++; if (pend1 !== 1'b1) begin bad++; $display("FAIL fps1_f1 pending got=%0b exp=1", pend1); end
      tick();
      frame();
      total++; if (sel1 !== 3'd1) begin bad++; $display("FAIL fps1_f2 select got=%0d exp=1", sel1); end
      total++; if (chg1 !== 1'b1) begin bad++; $display("FAIL fps1_f2 changed got=%0b exp=1", chg1); end
      frame();
      total++; if (sel1 !== 3'd2) begin bad++; $display("FAIL fps1_f3 select got=%0d exp=2", sel1); end
      total++; if (sel !== 3'd0) begin bad++; $display("FAIL fps3_f3 select got=%0d exp=0", sel); end
   endtask

   initial begin
      test_reset();
      test_button();
      test_back_to_back();
      test_manual();
      test_auto();
      test_reset_pending();
      test_fps_one();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
